// File: rtl/mips_core_pkg.sv
// Shared mips_core front-end types: per-thread run state and thread ids.
// The helper below resolves one thread's next run state from its control inputs.
package mips_core_pkg;

  localparam int NUM_THREADS_MAX = 4;

  typedef logic [$clog2(NUM_THREADS_MAX)-1:0] tid_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BLOCKED = 2'd1,
    HALTED  = 2'd2
  } thread_state_t;

  // Halt is sticky and beats everything; unblock beats a simultaneous block.
  function automatic thread_state_t next_state(input thread_state_t cur,
                                               input logic halt,
                                               input logic unblock,
                                               input logic block);
    thread_state_t nxt;
    nxt = cur;
    if (halt || cur == HALTED) nxt = HALTED;
    else if (unblock)          nxt = RUN;
    else if (block)            nxt = BLOCKED;
    return nxt;
  endfunction

endpackage

// File: rtl/rr_thread_picker.sv
// Round-robin picker: returns the first ready thread at or after start_i,
// wrapping modulo NUM_THREADS. Purely combinational.
module rr_thread_picker #(
  parameter int  NUM_THREADS = 2,
  localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic [NUM_THREADS-1:0] ready_i,
  input  logic [TID_W-1:0]       start_i,
  output logic [TID_W-1:0]       pick_o,
  output logic                   any_o
);

  logic [2*NUM_THREADS-1:0] ready_dbl;
  logic [NUM_THREADS-1:0]   ready_rot;
  int                       off;
  int                       sum;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    ready_dbl = {ready_i, ready_i};
    // Bit j of ready_rot is thread (start_i + j) mod NUM_THREADS.
    ready_rot = ready_dbl[start_i +: NUM_THREADS];
    off       = 0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (ready_rot[i]) off = i;
    end
    sum = int'(start_i) + off;
    if (sum >= NUM_THREADS) sum = sum - NUM_THREADS;
    pick_o = TID_W'(sum);
    any_o  = |ready_i;
  end

endmodule

// File: rtl/thread_fetch_scheduler.sv
// Fine-grained multithreading fetch controller: per-thread PC and run-state
// files, successor mux, and round-robin selection of the thread fed to i_cache.
module thread_fetch_scheduler
  import mips_core_pkg::*;
#(
  parameter int                    NUM_THREADS  = 2,
  parameter int                    ADDR_WIDTH   = 26,
  parameter logic [ADDR_WIDTH-1:0] START_STRIDE = '0,
  localparam int                   TID_W        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_stall,
  input  logic                   i_redirect_we,
  input  logic [TID_W-1:0]       i_redirect_tid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  input  logic                   i_pred_valid,
  input  logic                   i_pred_taken,
  input  logic [ADDR_WIDTH-1:0]  i_pred_target,
  input  logic [NUM_THREADS-1:0] i_block,
  input  logic [NUM_THREADS-1:0] i_unblock,
  input  logic [NUM_THREADS-1:0] i_halt,
  output logic [ADDR_WIDTH-1:0]  o_pc_current,
  output logic [TID_W-1:0]       o_tid_current,
  output logic                   o_fetch_valid,
  output logic [ADDR_WIDTH-1:0]  o_pc_next,
  output logic [TID_W-1:0]       o_tid_next,
  output logic                   o_switch
);

  logic [ADDR_WIDTH-1:0]  pc_q [NUM_THREADS];
  logic [ADDR_WIDTH-1:0]  pc_d [NUM_THREADS];
  thread_state_t          st_q [NUM_THREADS];
  thread_state_t          st_d [NUM_THREADS];
  logic [TID_W-1:0]       cur_tid_q;
  logic                   cur_valid_q;
  logic                   switch_q;

  logic                   redirect_cur;
  logic [ADDR_WIDTH-1:0]  pc_cur;
  logic [ADDR_WIDTH-1:0]  successor;
  logic [NUM_THREADS-1:0] ready;
  logic [TID_W-1:0]       start_tid;
  logic [TID_W-1:0]       pick_tid;
  logic                   pick_any;
  logic [TID_W-1:0]       tid_next;

  always_comb begin
    redirect_cur = cur_valid_q && i_redirect_we && (i_redirect_tid == cur_tid_q);
    pc_cur       = pc_q[cur_tid_q];
    // A resolved redirect always overrides the predictor for the same thread.
    if (redirect_cur)                     successor = i_redirect_pc;
    else if (i_pred_valid && i_pred_taken) successor = i_pred_target;
    else                                  successor = pc_cur + ADDR_WIDTH'(4);
  end

  // pc_d[t] is the value pc_q[t] takes at the next edge; o_pc_next reads it directly.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      st_d[t]  = next_state(st_q[t], i_halt[t], i_unblock[t], i_block[t]);
      ready[t] = (st_d[t] == RUN);
      pc_d[t]  = pc_q[t];
      if (cur_valid_q && (cur_tid_q == TID_W'(t))) begin
        if (!i_stall)          pc_d[t] = successor;
        else if (redirect_cur) pc_d[t] = i_redirect_pc;
      end else if (i_redirect_we && (i_redirect_tid == TID_W'(t)) && (st_q[t] != HALTED)) begin
        pc_d[t] = i_redirect_pc;
      end
    end
  end

  assign start_tid = (cur_tid_q == TID_W'(NUM_THREADS - 1)) ? '0 : cur_tid_q + TID_W'(1);

  rr_thread_picker #(
    .NUM_THREADS (NUM_THREADS)
  ) u_picker (
    .ready_i (ready),
    .start_i (start_tid),
    .pick_o  (pick_tid),
    .any_o   (pick_any)
  );

  assign tid_next = (!i_stall && pick_any) ? pick_tid : cur_tid_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the PC and state files are small flop arrays with defined start values, so they are reset; RAM-style storage would not be.
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= START_STRIDE * ADDR_WIDTH'(t);
        st_q[t] <= RUN;
      end
      cur_tid_q   <= '0;
      cur_valid_q <= 1'b1;
      switch_q    <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= pc_d[t];
        st_q[t] <= st_d[t];
      end
      if (!i_stall) begin
        cur_valid_q <= pick_any;
        if (pick_any) cur_tid_q <= pick_tid;
      end
      switch_q <= !i_stall && pick_any && (pick_tid != cur_tid_q);
    end
  end

  assign o_pc_current  = pc_cur;
  assign o_tid_current = cur_tid_q;
  assign o_fetch_valid = cur_valid_q;
  assign o_pc_next     = pc_d[tid_next];
  assign o_tid_next    = tid_next;
  assign o_switch      = switch_q;

endmodule
